// File: rtl/dbus_responder.sv
// Data-bus responder: serves dbus_req_t requests from a word-addressed 64-bit RAM
// with byte-strobe writes and a fixed, programmable response latency.

package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    strb_q, strb_d;
  logic [63:0]   wdata_q, wdata_d;

  logic [63:0]   mem [DEPTH];
  logic          accept;

  // size and the byte offset / upper address bits play no part in addressing
  logic unused_req;
  assign unused_req = ^{dreq.size, dreq.addr[63:AW+3], dreq.addr[2:0]};

  // Reset is folded in so no addr_ok is shown while the block is held in reset
  assign accept = reset && (state_q == StIdle) && dreq.valid;

  // Next-state: capture the request in IDLE, count down in WAIT, one-cycle RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (dreq.valid) begin
          idx_d   = dreq.addr[AW+2:3];
          strb_d  = dreq.strobe;
          wdata_d = dreq.data;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY <= 1) ? StResp : StWait;
        end
      end
      StWait: begin
        // Counter is entered at LATENCY-1; leaving at 1 puts RESP at T+LATENCY
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      strb_q  <= 8'd0;
      wdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
    end
  end

  // Byte-lane write at the edge ending RESP; an async reset drops RESP first
  always_ff @(posedge clk) begin
    if (state_q == StResp) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Response: data is the pre-write word during RESP and zero otherwise
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    if (state_q == StResp) begin
      dresp.data_ok = 1'b1;
      dresp.data    = mem[idx_q];
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench for dbus_responder: two instances (LATENCY=2 and LATENCY=1).

module tb_dbus_responder;
  import dbus_pkg::*;

  typedef struct {
    logic [63:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq2, dreq1;
  dbus_resp_t dresp2, dresp1;
  logic       busy2, busy1;

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q2[$], q1[$];
  exp_t e2, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_responder #(.DEPTH(1024), .LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq2),
    .dresp (dresp2),
    .busy  (busy2)
  );

  dbus_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq1),
    .dresp (dresp1),
    .busy  (busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int d, input logic v, input logic [63:0] a, input logic [7:0] s,
                         input logic [63:0] wd);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = 3'd3;
    r.strobe = s;
    r.data   = wd;
    if (d == 1) dreq1 = r;
    else dreq2 = r;
  endtask

  function automatic dbus_resp_t resp_of(input int d);
    return (d == 1) ? dresp1 : dresp2;
  endfunction

  task automatic push_exp(input int d, input logic [63:0] data, input int at, input bit chk);
    exp_t e;
    e.data = data;
    e.cyc  = at;
    e.chk  = chk;
    if (d == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // One transaction; called #1 after a rising edge. chk=0 skips the data compare.
  task automatic xact(input int d, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] wd, input bit chk, input logic [63:0] ed,
                      input bit perturb);
    int  lat;
    bit  seen;
    lat  = (d == 1) ? 1 : 2;
    seen = 0;
    set_req(d, 1'b1, a, s, wd);
    @(negedge clk);
    check($sformatf("addr_ok%0d", d), 64'(resp_of(d).addr_ok), 64'd1);
    push_exp(d, ed, cyc + lat, chk);
    if (perturb) begin
      @(posedge clk);
      #1;
      set_req(d, 1'b1, ~a, s, ~wd);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_of(d).data_ok) seen = 1;
    end
    if (!seen) check($sformatf("timeout%0d", d), 64'd0, 64'd1);
    @(posedge clk);
    #1;
    set_req(d, 1'b0, 64'd0, 8'd0, 64'd0);
  endtask

  // Monitor: pop and compare on every data_ok; data must be zero outside RESP
  always @(negedge clk) begin
    if (dresp2.data_ok) begin
      if (q2.size() == 0) check("unexpected_data_ok2", 64'd1, 64'd0);
      else begin
        e2 = q2.pop_front();
        check("lat2", 64'(cyc), 64'(e2.cyc));
        if (e2.chk) check("rdata2", dresp2.data, e2.data);
      end
      check("ok_overlap2", 64'(dresp2.addr_ok), 64'd0);
    end else begin
      check("idle_data2", dresp2.data, 64'd0);
    end
    if (dresp1.data_ok) begin
      if (q1.size() == 0) check("unexpected_data_ok1", 64'd1, 64'd0);
      else begin
        e1 = q1.pop_front();
        check("lat1", 64'(cyc), 64'(e1.cyc));
        if (e1.chk) check("rdata1", dresp1.data, e1.data);
      end
      check("ok_overlap1", 64'(dresp1.addr_ok), 64'd0);
    end
  end

  initial begin
    reset = 1'b0;
    set_req(2, 1'b1, 64'h10, 8'h00, 64'd0);
    set_req(1, 1'b1, 64'h10, 8'h00, 64'd0);

    // Reset held with valid high: everything stays quiet
    repeat (3) begin
      @(negedge clk);
      check("rst_resp2", 64'(dresp2), 64'd0);
      check("rst_busy2", 64'(busy2), 64'd0);
      check("rst_resp1", 64'(dresp1), 64'd0);
    end
    set_req(2, 1'b0, 64'd0, 8'd0, 64'd0);
    set_req(1, 1'b0, 64'd0, 8'd0, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_addr_ok2", 64'(dresp2.addr_ok), 64'd0);
    check("idle_busy2", 64'(busy2), 64'd0);
    @(posedge clk);
    #1;

    // Full-word write then read
    xact(2, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 0, 64'd0, 0);
    xact(2, 64'h8000_0010, 8'h00, 64'd0, 1, 64'h1122334455667788, 0);

    // Byte-strobe merge; the write response carries the pre-write word
    xact(2, 64'h8000_0018, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 0);
    xact(2, 64'h8000_0018, 8'h0F, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    xact(2, 64'h8000_0018, 8'h00, 64'd0, 1, 64'hFFFF_FFFF_0000_0000, 0);

    // Wrap-around: 0x2000 is word 1024, which aliases word 0
    xact(2, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 0, 64'd0, 0);
    xact(2, 64'h2000, 8'h01, 64'hA5, 1, 64'h0123456789ABCDEF, 0);
    xact(2, 64'h0, 8'h00, 64'd0, 1, 64'h0123456789ABCDA5, 0);

    // Request changes during WAIT are ignored
    xact(2, 64'h200, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, 64'd0, 1);
    xact(2, 64'h200, 8'h00, 64'd0, 1, 64'hDEADBEEFCAFEF00D, 1);

    // Reset during WAIT of a write to 0x40 aborts it
    xact(2, 64'h40, 8'hFF, 64'h5555_6666_7777_8888, 0, 64'd0, 0);
    set_req(2, 1'b1, 64'h40, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    check("abort_addr_ok", 64'(dresp2.addr_ok), 64'd1);
    @(posedge clk);
    #1;
    check("abort_busy_wait", 64'(busy2), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_resp", 64'(dresp2), 64'd0);
    check("abort_busy", 64'(busy2), 64'd0);
    set_req(2, 1'b0, 64'd0, 8'd0, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    xact(2, 64'h40, 8'h00, 64'd0, 1, 64'h5555_6666_7777_8888, 0);

    // LATENCY=1: valid held high across two reads
    xact(1, 64'h100, 8'hFF, 64'h0A0A_0A0A_0A0A_0A0A, 0, 64'd0, 0);
    xact(1, 64'h108, 8'hFF, 64'h0B0B_0B0B_0B0B_0B0B, 0, 64'd0, 0);
    set_req(1, 1'b1, 64'h100, 8'h00, 64'd0);
    @(negedge clk);
    check("b2b_addr_ok_t", 64'(dresp1.addr_ok), 64'd1);
    push_exp(1, 64'h0A0A_0A0A_0A0A_0A0A, cyc + 1, 1);
    @(posedge clk);
    #1;
    set_req(1, 1'b1, 64'h108, 8'h00, 64'd0);
    @(negedge clk);
    check("b2b_addr_ok_t1", 64'(dresp1.addr_ok), 64'd0);
    check("b2b_data_ok_t1", 64'(dresp1.data_ok), 64'd1);
    @(negedge clk);
    check("b2b_addr_ok_t2", 64'(dresp1.addr_ok), 64'd1);
    push_exp(1, 64'h0B0B_0B0B_0B0B_0B0B, cyc + 1, 1);
    @(negedge clk);
    check("b2b_data_ok_t3", 64'(dresp1.data_ok), 64'd1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 64'd0, 8'd0, 64'd0);

    repeat (4) @(negedge clk);
    check("q2_drained", 64'(q2.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
